// File: rtl/crtc_loader.sv
// Programs all 16 CRTC registers as address/data bus cycles separated by idle gaps,
// with an optional readback of R14/R15 that raises a sticky error flag on mismatch.
module crtc_loader (
  input  logic         clk,
  input  logic         RESET,
  input  logic         en,
  input  logic         start,
  input  logic         verify_en,
  input  logic [127:0] reg_values,
  input  logic [7:0]   data_in,
  output logic         nCS,
  output logic         RnW,
  output logic         RS,
  output logic [7:0]   data_out,
  output logic         data_oe,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_DATA, S_GAP, S_DONE
  } state_t;

  state_t       r_state;
  state_t       r_prev;
  logic [3:0]   r_idx;
  logic [127:0] r_regs;
  logic         r_verify;
  logic         r_error;

  state_t       w_next_state;
  logic [3:0]   w_next_idx;
  logic [7:0]   w_reg_byte;
  logic         w_rd_mismatch;

  assign w_reg_byte    = r_regs[{r_idx, 3'b000} +: 8];
  // R14 only holds six significant bits on the CRTC, so the top two read back as don't-care.
  assign w_rd_mismatch = (r_idx == 4'd14) ? ((data_in & 8'h3F) != (w_reg_byte & 8'h3F))
                                          : (data_in != w_reg_byte);

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_WR_ADDR;
          w_next_idx   = 4'd0;
        end
      end
      S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_DATA: w_next_state = S_GAP;
      S_GAP: begin
        // The gap's successor depends on which bus cycle it followed.
        case (r_prev)
          S_WR_ADDR: w_next_state = S_WR_DATA;
          S_WR_DATA: begin
            if (r_idx == 4'd15) begin
              if (r_verify) begin
                w_next_state = S_RD_ADDR;
                w_next_idx   = 4'd14;
              end else begin
                w_next_state = S_DONE;
              end
            end else begin
              w_next_state = S_WR_ADDR;
              w_next_idx   = r_idx + 4'd1;
            end
          end
          S_RD_ADDR: w_next_state = S_RD_DATA;
          S_RD_DATA: begin
            if (r_idx == 4'd14) begin
              w_next_state = S_RD_ADDR;
              w_next_idx   = 4'd15;
            end else begin
              w_next_state = S_DONE;
            end
          end
          default: w_next_state = S_DONE;
        endcase
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_prev   <= S_IDLE;
      r_idx    <= 4'd0;
      r_regs   <= '0;
      r_verify <= 1'b0;
      r_error  <= 1'b0;
    end else if (en) begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      if (w_next_state == S_GAP) begin
        r_prev <= r_state;
      end
      if (r_state == S_IDLE && start) begin
        r_regs   <= reg_values;
        r_verify <= verify_en;
        r_error  <= 1'b0;
      end
      if (r_state == S_RD_DATA && w_rd_mismatch) begin
        r_error <= 1'b1;
      end
    end
  end

  always_comb begin
    nCS      = 1'b1;
    RnW      = 1'b1;
    RS       = 1'b0;
    data_out = 8'h00;
    data_oe  = 1'b0;
    done     = 1'b0;
    busy     = (r_state != S_IDLE);
    error    = r_error;
    case (r_state)
      S_WR_ADDR, S_RD_ADDR: begin
        nCS      = 1'b0;
        RnW      = 1'b0;
        data_out = {4'b0000, r_idx};
        data_oe  = 1'b1;
      end
      S_WR_DATA: begin
        nCS      = 1'b0;
        RnW      = 1'b0;
        RS       = 1'b1;
        data_out = w_reg_byte;
        data_oe  = 1'b1;
      end
      S_RD_DATA: begin
        nCS = 1'b0;
        RS  = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_crtc_loader.sv
// Bench for crtc_loader: per-clock comparison of the whole output bundle against an
// expected bus-cycle list built directly from the register-programming rules.
module tb_crtc_loader;

  logic         clk = 1'b0;
  logic         RESET;
  logic         en;
  logic         start;
  logic         verify_en;
  logic [127:0] reg_values;
  logic [7:0]   data_in;
  logic         nCS, RnW, RS, data_oe, busy, done, error;
  logic [7:0]   data_out;

  int checks = 0;
  int errors = 0;

  logic [14:0] exp_q[$];
  logic [7:0]  rd_q[$];
  logic        prev_err;
  logic [14:0] obs;

  assign obs = {nCS, RnW, RS, data_oe, data_out, busy, done, error};

  crtc_loader dut (
    .clk(clk), .RESET(RESET), .en(en), .start(start), .verify_en(verify_en),
    .reg_values(reg_values), .data_in(data_in), .nCS(nCS), .RnW(RnW), .RS(RS),
    .data_out(data_out), .data_oe(data_oe), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] ent(input logic ncs, input logic rnw, input logic rs,
                                      input logic oe, input logic [7:0] d, input logic b,
                                      input logic dn, input logic er);
    return {ncs, rnw, rs, oe, d, b, dn, er};
  endfunction

  task automatic check_bus(input string tag, input logic [14:0] o, input logic [14:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // Expected output per en-cycle: [0] idle before start, then each bus state, DONE, idle.
  task automatic build(input logic [7:0] r[16], input bit v, input logic [7:0] d14,
                       input logic [7:0] d15);
    logic err;
    logic [7:0] rd;
    err = 1'b0;
    exp_q.delete();
    rd_q.delete();
    exp_q.push_back(ent(1, 1, 0, 0, 8'h00, 0, 0, prev_err));
    rd_q.push_back(8'($urandom));
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(ent(0, 0, 0, 1, 8'(i), 1, 0, 0));
      exp_q.push_back(ent(1, 1, 0, 0, 8'h00, 1, 0, 0));
      exp_q.push_back(ent(0, 0, 1, 1, r[i], 1, 0, 0));
      exp_q.push_back(ent(1, 1, 0, 0, 8'h00, 1, 0, 0));
      repeat (4) rd_q.push_back(8'($urandom));
    end
    if (v) begin
      for (int k = 14; k < 16; k++) begin
        rd = (k == 14) ? d14 : d15;
        exp_q.push_back(ent(0, 0, 0, 1, 8'(k), 1, 0, err));
        exp_q.push_back(ent(1, 1, 0, 0, 8'h00, 1, 0, err));
        exp_q.push_back(ent(0, 1, 1, 0, 8'h00, 1, 0, err));
        if (k == 14) err = err | ((rd % 64) != (r[14] % 64));
        else         err = err | (rd != r[15]);
        exp_q.push_back(ent(1, 1, 0, 0, 8'h00, 1, 0, err));
        rd_q.push_back(8'($urandom));
        rd_q.push_back(8'($urandom));
        rd_q.push_back(rd);
        rd_q.push_back(8'($urandom));
      end
    end
    exp_q.push_back(ent(1, 1, 0, 0, 8'h00, 1, 1, err));
    exp_q.push_back(ent(1, 1, 0, 0, 8'h00, 0, 0, err));
    rd_q.push_back(8'($urandom));
    rd_q.push_back(8'($urandom));
    prev_err = err;
  endtask

  task automatic run(input string tag, input logic [7:0] r[16], input bit v,
                     input logic [7:0] d14, input logic [7:0] d15, input int period,
                     input bit pulse, input int abort_pos);
    int pos, cyc, n_lo, n_done, done_pos, last;
    bit started;
    build(r, v, d14, d15);
    for (int i = 0; i < 16; i++) reg_values[i*8 +: 8] = r[i];
    verify_en = v;
    pos = 0; cyc = 0; n_lo = 0; n_done = 0; done_pos = 0; started = 0;
    last = exp_q.size() - 1;
    while (1) begin
      en = ((cyc % period) == period - 1);
      cyc++;
      if (pos == 0 && !started) start = 1'b1;
      else if (pulse && pos >= 1 && pos <= last - 2) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      data_in = rd_q[pos];
      @(posedge clk);
      if (en) begin
        if (pos == 0) begin
          if (start) begin
            pos = 1;
            started = 1;
          end
        end else begin
          pos++;
        end
      end
      #1;
      check_bus(tag, obs, exp_q[pos]);
      if (!nCS) n_lo++;
      if (done) begin
        n_done++;
        if (done_pos == 0) done_pos = pos;
      end
      if (abort_pos != 0 && pos == abort_pos) begin
        start = 1'b0;
        en = 1'b0;
        #2 RESET = 1'b1;
        #1;
        check_bus({tag, "_async_rst"}, obs, ent(1, 1, 0, 0, 8'h00, 0, 0, 0));
        @(posedge clk);
        #1;
        check_bus({tag, "_rst_hold"}, obs, ent(1, 1, 0, 0, 8'h00, 0, 0, 0));
        @(negedge clk);
        RESET = 1'b0;
        prev_err = 1'b0;
        return;
      end
      if (started && pos == last) break;
    end
    start = 1'b0;
    en = 1'b0;
    check_int({tag, "_ncs_low_clks"}, n_lo, (v ? 36 : 32) * period);
    check_int({tag, "_done_clks"}, n_done, period);
    check_int({tag, "_done_encycle"}, done_pos, v ? 73 : 65);
  endtask

  initial begin
    logic [7:0] std_r[16];
    logic [7:0] rnd_r[16];
    bit         v;
    logic [7:0] d14, d15;

    std_r = '{8'h65, 8'h50, 8'h56, 8'h09, 8'h18, 8'h0A, 8'h18, 8'h18,
              8'h00, 8'h0B, 8'h00, 8'h0B, 8'h00, 8'h80, 8'h00, 8'h80};
    RESET = 1'b0; en = 1'b0; start = 1'b0; verify_en = 1'b0;
    reg_values = '0; data_in = 8'h00; prev_err = 1'b0;

    #1 RESET = 1'b1;
    #2;
    check_bus("reset_async", obs, ent(1, 1, 0, 0, 8'h00, 0, 0, 0));
    en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    check_bus("reset_hold_start", obs, ent(1, 1, 0, 0, 8'h00, 0, 0, 0));
    start = 1'b0; en = 1'b0;
    @(negedge clk);
    RESET = 1'b0;

    run("write_only", std_r, 0, 8'h00, 8'h00, 1, 0, 0);
    run("verify_pass", std_r, 1, 8'hC0, 8'h80, 1, 0, 0);
    run("verify_fail", std_r, 1, 8'hC0, 8'h81, 1, 0, 0);
    check_int("error_sticky", int'(error), 1);
    run("clear_on_start", std_r, 0, 8'h00, 8'h00, 2, 0, 0);
    run("en_gated", std_r, 1, 8'h00, 8'h80, 4, 1, 0);
    run("abort_wr_data7", std_r, 0, 8'h00, 8'h00, 1, 1, 31);
    run("restart_after_rst", std_r, 0, 8'h00, 8'h00, 1, 0, 0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) rnd_r[i] = 8'($urandom);
      v   = 1'($urandom_range(0, 1));
      d14 = $urandom_range(0, 1) ? (rnd_r[14] ^ 8'($urandom_range(0, 3) << 6)) : 8'($urandom);
      d15 = $urandom_range(0, 1) ? rnd_r[15] : 8'($urandom);
      run("random", rnd_r, v, d14, d15, $urandom_range(1, 3), 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crtc_loader.md
CRTC_LOADER -- requirements
Module: crtc_loader

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 RESET  input  1  asynchronous, active-high reset.
REQ-003 en  input  1  bus-cycle enable; state advances only on clk edges with en=1.
REQ-004 start  input  1  request to program all 16 CRTC registers.
REQ-005 verify_en  input  1  when 1 at start acceptance, adds readback of R14/R15 after the writes.
REQ-006 reg_values  input  128  R0 in bits 7:0 through R15 in bits 127:120; latched at start acceptance.
REQ-007 data_in  input  8  CRTC data bus, sampled during reads.
REQ-008 nCS  output  1  CRTC chip select, active low.
REQ-009 RnW  output  1  1 = read, 0 = write.
REQ-010 RS  output  1  0 = address register, 1 = data register.
REQ-011 data_out  output  8  value driven onto the CRTC bus.
REQ-012 data_oe  output  1  data_out is valid and must be driven onto the bus.
REQ-013 busy  output  1  sequence in progress.
REQ-014 done  output  1  high for exactly the one en-cycle of state DONE.
REQ-015 error  output  1  readback mismatch; sticky until the next start is accepted.

Function
REQ-016 States are IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, GAP, DONE; each non-IDLE state lasts exactly one en-cycle; en=0 holds all state.
REQ-017 Accept start only in IDLE on an en=1 edge; at acceptance latch reg_values and verify_en, clear error, set busy, and set index to 0.
REQ-018 Start while busy shall be ignored.
REQ-019 Write sequence for i = 0..15: WR_ADDR(i), GAP, WR_DATA(i), GAP.
REQ-020 WR_ADDR: nCS=0, RS=0, RnW=0, data_out={4'b0,i}, data_oe=1.
REQ-021 WR_DATA: nCS=0, RS=1, RnW=0, data_out=R[i], data_oe=1.
REQ-022 GAP and IDLE: nCS=1, RnW=1, RS=0, data_oe=0, data_out=0.
REQ-023 After the final GAP of R15: if the latched verify_en=1, run RD_ADDR(14), GAP, RD_DATA, GAP, RD_ADDR(15), GAP, RD_DATA, GAP; otherwise go directly to DONE.
REQ-024 RD_ADDR is identical to WR_ADDR for the given index.
REQ-025 RD_DATA: nCS=0, RS=1, RnW=1, data_oe=0; sample data_in on the en=1 edge leaving the state.
REQ-026 Compare for R14: (data_in & 8'h3F) != (R14 & 8'h3F) sets error.
REQ-027 Compare for R15: data_in != R15 sets error.
REQ-028 DONE: bus idle as in GAP, done=1, busy=1; next state is IDLE, where busy=0.
REQ-029 Total sequence length is 64 en-cycles without verify, 72 with verify, plus 1 en-cycle of DONE.
REQ-030 All outputs are decoded from registered state and the latched data only; there is no combinational path from inputs to outputs.
REQ-031 The index counter is 4 bits; the transition from R15 to the next phase is taken on index==15 and never wraps to R0.

Reset
REQ-032 RESET=1 immediately forces IDLE and sets nCS=1, RnW=1, RS=0, data_oe=0, data_out=0, busy=0, done=0, error=0, with index and latches at 0.
REQ-033 RESET asserted mid-sequence releases the bus at once; no partial cycle completes; start is honoured again after RESET falls.

Verification
REQ-034 Write-only run: start with reg_values = 65,50,56,09,18,0A,18,18,00,0B,00,0B,00,80,00,80 (hex, R0 first) and verify_en=0 -> exactly 32 nCS-low cycles, alternating RS=0 (data 0..F) and RS=1 (data as listed); done pulses at en-cycle 65; busy=0 after.
REQ-035 Verify pass: same values with verify_en=1; the bench returns data_in=8'hC0 for R14 and 8'h80 for R15 -> error=0 (R14 masked), done at en-cycle 73.
REQ-036 Verify fail: the bench returns 8'h81 for R15 -> error=1 after DONE and held until the next start is accepted, which clears it.
REQ-037 en gating: en=1 only every 4th clk -> same bus sequence, each state lasting 4 clks; start pulsed while busy -> ignored.
REQ-038 Reset mid-run: RESET during WR_DATA(7) -> nCS=1 and data_oe=0 asynchronously; a new start restarts at WR_ADDR(0).
